data_mem_access_unit: RTL and testbench



---
 rtl/data_mem_access_unit.sv | 191 +++++++++++++++++++
 tb/tb_data_mem_access_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit: load/store stage driving a single-outstanding req/ack data bus.
// Optional build macro MISALIGN_TRAP_EN adds misalign_err and skips the bus for misaligned starts.
module data_mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        load_unsigned,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        done,
    output logic        timeout_err
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misalign_err
`endif
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  sel_q;
    logic [31:0] ldata_q;
    logic        done_q;
    logic        tout_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [CW-1:0] cnt_q;

    logic        start;
    logic [1:0]  off_d;
    logic [3:0]  sel_d;
    logic [31:0] wdata_d;

    assign start = mem_read | mem_write;
    assign off_d = alu_result[1:0];

    // Sign/zero-extend the addressed byte or halfword of the returned word.
    function automatic logic [31:0] extend(
        input logic [31:0] rd,
        input logic [1:0]  sz,
        input logic [1:0]  off,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{off, 3'b000} +: 8];
        h = rd[{off[1], 4'b0000} +: 16];
        case (sz)
            2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: return rd;
        endcase
    endfunction

    // Steer store data and byte enables into the lanes selected by the address.
    always_comb begin
        sel_d   = 4'b1111;
        wdata_d = store_data;
        case (mem_size)
            2'b00: begin
                sel_d   = 4'b0001 << off_d;
                wdata_d = {4{store_data[7:0]}};
            end
            2'b01: begin
                sel_d   = 4'b0011 << {off_d[1], 1'b0};
                wdata_d = {2{store_data[15:0]}};
            end
            default: begin
                sel_d   = 4'b1111;
                wdata_d = store_data;
            end
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic misal;
    logic mis_q;
    assign misal = ((mem_size == 2'b01) && off_d[0]) ||
                   (mem_size[1] && (off_d != 2'b00));
    assign misalign_err = mis_q;
`endif

    // Access sequencer: IDLE -> REQ -> DONE with registered bus and status outputs.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            ldata_q <= '0;
            done_q  <= 1'b0;
            tout_q  <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            off_q   <= '0;
            cnt_q   <= '0;
`ifdef MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            tout_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            mis_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (start) begin
`ifdef MISALIGN_TRAP_EN
                        if (misal) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            mis_q   <= 1'b1;
                        end else
`endif
                        begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                            we_q    <= mem_write;
                            addr_q  <= {alu_result[31:2], 2'b00};
                            wdata_q <= wdata_d;
                            sel_q   <= sel_d;
                            size_q  <= mem_size;
                            uns_q   <= load_unsigned;
                            off_q   <= off_d;
                            cnt_q   <= '0;
                        end
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        state_q <= DONE;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        if (!we_q)
                            ldata_q <= extend(bus_rdata, size_q, off_q, uns_q);
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        tout_q  <= 1'b1;
                        if (!we_q)
                            ldata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall       = ((state_q == IDLE) && start) || (state_q == REQ);
    assign bus_req     = req_q;
    assign bus_we      = we_q;
    assign bus_addr    = addr_q;
    assign bus_wdata   = wdata_q;
    assign bus_sel     = sel_q;
    assign load_data   = ldata_q;
    assign done        = done_q;
    assign timeout_err = tout_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// tb_data_mem_access_unit: directed checks of the load/store access unit.
// A second instance with a short timeout exercises the abort path.
module tb_data_mem_access_unit;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic [31:0] alu_result = '0;
    logic [31:0] store_data = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  mem_size = '0;
    logic        load_unsigned = 1'b0;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        mem_read2 = 1'b0;

    logic        bus_req, bus_we, stall, done, timeout_err;
    logic [31:0] bus_addr, bus_wdata, load_data;
    logic [3:0]  bus_sel;
    logic        t_req, t_we, t_stall, t_done, t_tout;
    logic [31:0] t_addr, t_wdata, t_ldata;
    logic [3:0]  t_sel;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_err, t_mis;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    data_mem_access_unit u_dut (
        .clk(clk), .nRst(nRst), .alu_result(alu_result), .store_data(store_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .load_unsigned(load_unsigned), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .stall(stall),
        .load_data(load_data), .done(done), .timeout_err(timeout_err)
`ifdef MISALIGN_TRAP_EN
        , .misalign_err(misalign_err)
`endif
    );

    data_mem_access_unit #(.TIMEOUT_CYCLES(4)) u_to (
        .clk(clk), .nRst(nRst), .alu_result(alu_result), .store_data(store_data),
        .mem_read(mem_read2), .mem_write(1'b0), .mem_size(mem_size),
        .load_unsigned(load_unsigned), .bus_req(t_req), .bus_we(t_we),
        .bus_addr(t_addr), .bus_wdata(t_wdata), .bus_sel(t_sel),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .stall(t_stall),
        .load_data(t_ldata), .done(t_done), .timeout_err(t_tout)
`ifdef MISALIGN_TRAP_EN
        , .misalign_err(t_mis)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        nvec++; if (bus_req !== 1'b0) begin nerr++; $display("FAIL rst_req got %0h want 0", bus_req); end
        nvec++; if (bus_we !== 1'b0) begin nerr++; $display("FAIL rst_we got %0h want 0", bus_we); end
        nvec++; if (bus_addr !== 32'h0) begin nerr++; $display("FAIL rst_addr got %08h want 0", bus_addr); end
        nvec++; if (bus_wdata !== 32'h0) begin nerr++; $display("FAIL rst_wdata got %08h want 0", bus_wdata); end
        nvec++; if (bus_sel !== 4'b0000) begin nerr++; $display("FAIL rst_sel got %b want 0000", bus_sel); end
        nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL rst_stall got %0h want 0", stall); end
        nvec++; if (load_data !== 32'h0) begin nerr++; $display("FAIL rst_ldata got %08h want 0", load_data); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rst_done got %0h want 0", done); end
        nvec++; if (timeout_err !== 1'b0) begin nerr++; $display("FAIL rst_tout got %0h want 0", timeout_err); end
        nRst = 1'b1;
        tick();
    endtask

    task automatic test_word_load();
        alu_result = 32'h100; mem_size = 2'b10; load_unsigned = 1'b0; mem_read = 1'b1;
        #1;
        nvec++; if (stall !== 1'b1) begin nerr++; $display("FAIL wl_stall_c1 got %0h want 1", stall); end
        tick();
        nvec++; if (bus_req !== 1'b1) begin nerr++; $display("FAIL wl_req got %0h want 1", bus_req); end
        nvec++; if (bus_we !== 1'b0) begin nerr++; $display("FAIL wl_we got %0h want 0", bus_we); end
        nvec++; if (bus_addr !== 32'h100) begin nerr++; $display("FAIL wl_addr got %08h want 00000100", bus_addr); end
        nvec++; if (bus_sel !== 4'b1111) begin nerr++; $display("FAIL wl_sel got %b want 1111", bus_sel); end
        nvec++; if (stall !== 1'b1) begin nerr++; $display("FAIL wl_stall_c2 got %0h want 1", stall); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL wl_done_c2 got %0h want 0", done); end
        bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
        tick();
        bus_ack = 1'b0;
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL wl_done_c3 got %0h want 1", done); end
        nvec++; if (load_data !== 32'hDEADBEEF) begin nerr++; $display("FAIL wl_ldata got %08h want DEADBEEF", load_data); end
        nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL wl_stall_c3 got %0h want 0", stall); end
        nvec++; if (bus_req !== 1'b0) begin nerr++; $display("FAIL wl_req_c3 got %0h want 0", bus_req); end
        nvec++; if (timeout_err !== 1'b0) begin nerr++; $display("FAIL wl_tout got %0h want 0", timeout_err); end
        mem_read = 1'b0;
        tick();
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL wl_done_c4 got %0h want 0", done); end
    endtask

    task automatic test_byte_load();
        logic [31:0] exp;
        for (int u = 0; u < 2; u++) begin
            exp = (u == 1) ? 32'h00000080 : 32'hFFFFFF80;
            alu_result = 32'h203; mem_size = 2'b00; load_unsigned = u[0]; mem_read = 1'b1;
            tick();
            nvec++; if (bus_sel !== 4'b1000) begin nerr++; $display("FAIL bl_sel u=%0d got %b want 1000", u, bus_sel); end
            nvec++; if (bus_addr !== 32'h200) begin nerr++; $display("FAIL bl_addr u=%0d got %08h want 00000200", u, bus_addr); end
            bus_ack = 1'b1; bus_rdata = 32'h80000000;
            tick();
            bus_ack = 1'b0; mem_read = 1'b0;
            nvec++; if (load_data !== exp) begin nerr++; $display("FAIL bl_ldata u=%0d got %08h want %08h", u, load_data, exp); end
            tick();
        end
        alu_result = 32'h206; mem_size = 2'b01; load_unsigned = 1'b0; mem_read = 1'b1;
        tick();
        nvec++; if (bus_sel !== 4'b1100) begin nerr++; $display("FAIL hl_sel got %b want 1100", bus_sel); end
        bus_ack = 1'b1; bus_rdata = 32'h80011234;
        tick();
        bus_ack = 1'b0; mem_read = 1'b0;
        nvec++; if (load_data !== 32'hFFFF8001) begin nerr++; $display("FAIL hl_ldata got %08h want FFFF8001", load_data); end
        tick();
    endtask

    task automatic test_half_store();
        alu_result = 32'h302; mem_size = 2'b01; store_data = 32'h0000ABCD; mem_write = 1'b1;
        #1;
        nvec++; if (stall !== 1'b1) begin nerr++; $display("FAIL hs_stall_c1 got %0h want 1", stall); end
        tick();
        for (int k = 0; k < 5; k++) begin
            nvec++; if (bus_req !== 1'b1) begin nerr++; $display("FAIL hs_req k=%0d got %0h want 1", k, bus_req); end
            nvec++; if (bus_we !== 1'b1) begin nerr++; $display("FAIL hs_we k=%0d got %0h want 1", k, bus_we); end
            nvec++; if (bus_sel !== 4'b1100) begin nerr++; $display("FAIL hs_sel k=%0d got %b want 1100", k, bus_sel); end
            nvec++; if (bus_wdata !== 32'hABCDABCD) begin nerr++; $display("FAIL hs_wdata k=%0d got %08h want ABCDABCD", k, bus_wdata); end
            nvec++; if (bus_addr !== 32'h300) begin nerr++; $display("FAIL hs_addr k=%0d got %08h want 00000300", k, bus_addr); end
            nvec++; if (stall !== 1'b1) begin nerr++; $display("FAIL hs_stall k=%0d got %0h want 1", k, stall); end
            if (k == 4) begin bus_ack = 1'b1; bus_rdata = 32'h5555AAAA; end
            tick();
        end
        bus_ack = 1'b0; mem_write = 1'b0;
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL hs_done_c7 got %0h want 1", done); end
        nvec++; if (load_data !== 32'hFFFF8001) begin nerr++; $display("FAIL hs_ldata_kept got %08h want FFFF8001", load_data); end
        tick();
    endtask

    task automatic test_timeout();
        alu_result = 32'h400; mem_size = 2'b10; load_unsigned = 1'b0; mem_read2 = 1'b1;
        tick();
        bus_ack = 1'b1; bus_rdata = 32'h12345678;
        tick();
        bus_ack = 1'b0; mem_read2 = 1'b0;
        nvec++; if (t_ldata !== 32'h12345678) begin nerr++; $display("FAIL to_pre_ldata got %08h want 12345678", t_ldata); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL to_main_idle got %0h want 0", done); end
        tick();
        mem_read2 = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            nvec++; if (t_req !== 1'b1) begin nerr++; $display("FAIL to_req k=%0d got %0h want 1", k, t_req); end
            nvec++; if (t_done !== 1'b0) begin nerr++; $display("FAIL to_done_early k=%0d got %0h want 0", k, t_done); end
            tick();
        end
        mem_read2 = 1'b0;
        nvec++; if (t_req !== 1'b0) begin nerr++; $display("FAIL to_req_end got %0h want 0", t_req); end
        nvec++; if (t_done !== 1'b1) begin nerr++; $display("FAIL to_done got %0h want 1", t_done); end
        nvec++; if (t_tout !== 1'b1) begin nerr++; $display("FAIL to_tout got %0h want 1", t_tout); end
        nvec++; if (t_ldata !== 32'h0) begin nerr++; $display("FAIL to_ldata got %08h want 0", t_ldata); end
        tick();
        nvec++; if (t_tout !== 1'b0) begin nerr++; $display("FAIL to_tout_pulse got %0h want 0", t_tout); end
    endtask

    task automatic test_reset_mid();
        alu_result = 32'h500; mem_size = 2'b10; mem_read = 1'b1;
        tick();
        nvec++; if (bus_req !== 1'b1) begin nerr++; $display("FAIL rm_req got %0h want 1", bus_req); end
        nRst = 1'b0; mem_read = 1'b0;
        #1;
        nvec++; if (bus_req !== 1'b0) begin nerr++; $display("FAIL rm_req_async got %0h want 0", bus_req); end
        nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL rm_stall got %0h want 0", stall); end
        tick();
        nRst = 1'b1;
        tick();
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        tick();
        bus_ack = 1'b0;
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rm_stray_done got %0h want 0", done); end
        nvec++; if (load_data !== 32'h0) begin nerr++; $display("FAIL rm_stray_ldata got %08h want 0", load_data); end
        tick();
        alu_result = 32'h504; mem_read = 1'b1;
        tick();
        nvec++; if (bus_addr !== 32'h504) begin nerr++; $display("FAIL rm_addr got %08h want 00000504", bus_addr); end
        bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
        tick();
        bus_ack = 1'b0; mem_read = 1'b0;
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL rm_done got %0h want 1", done); end
        nvec++; if (load_data !== 32'hCAFEF00D) begin nerr++; $display("FAIL rm_ldata got %08h want CAFEF00D", load_data); end
        tick();
    endtask

    task automatic test_back_to_back();
        alu_result = 32'h600; mem_size = 2'b00; load_unsigned = 1'b0; mem_read = 1'b1;
        tick();
        bus_ack = 1'b1; bus_rdata = 32'h000000FE;
        tick();
        bus_ack = 1'b0;
        nvec++; if (load_data !== 32'hFFFFFFFE) begin nerr++; $display("FAIL bb_ldata1 got %08h want FFFFFFFE", load_data); end
        alu_result = 32'h601; load_unsigned = 1'b1;
        tick();
        nvec++; if (bus_req !== 1'b0) begin nerr++; $display("FAIL bb_req_idle got %0h want 0", bus_req); end
        nvec++; if (stall !== 1'b1) begin nerr++; $display("FAIL bb_stall_idle got %0h want 1", stall); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL bb_done_idle got %0h want 0", done); end
        tick();
        nvec++; if (bus_sel !== 4'b0010) begin nerr++; $display("FAIL bb_sel got %b want 0010", bus_sel); end
        nvec++; if (bus_wdata !== 32'hCDCDCDCD) begin nerr++; $display("FAIL bb_wdata got %08h want CDCDCDCD", bus_wdata); end
        bus_ack = 1'b1; bus_rdata = 32'h0000AB00;
        tick();
        bus_ack = 1'b0; mem_read = 1'b0;
        nvec++; if (load_data !== 32'h000000AB) begin nerr++; $display("FAIL bb_ldata2 got %08h want 000000AB", load_data); end
        tick();
    endtask

    task automatic test_misalign();
        alu_result = 32'h101; mem_size = 2'b10; load_unsigned = 1'b0; mem_read = 1'b1;
        #1;
        nvec++; if (stall !== 1'b1) begin nerr++; $display("FAIL ma_stall got %0h want 1", stall); end
        tick();
`ifdef MISALIGN_TRAP_EN
        mem_read = 1'b0;
        nvec++; if (bus_req !== 1'b0) begin nerr++; $display("FAIL ma_req got %0h want 0", bus_req); end
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL ma_done got %0h want 1", done); end
        nvec++; if (misalign_err !== 1'b1) begin nerr++; $display("FAIL ma_err got %0h want 1", misalign_err); end
        nvec++; if (load_data !== 32'h000000AB) begin nerr++; $display("FAIL ma_ldata got %08h want 000000AB", load_data); end
        tick();
        nvec++; if (misalign_err !== 1'b0) begin nerr++; $display("FAIL ma_err_pulse got %0h want 0", misalign_err); end
`else
        nvec++; if (bus_req !== 1'b1) begin nerr++; $display("FAIL ma_req got %0h want 1", bus_req); end
        nvec++; if (bus_addr !== 32'h100) begin nerr++; $display("FAIL ma_addr got %08h want 00000100", bus_addr); end
        nvec++; if (bus_sel !== 4'b1111) begin nerr++; $display("FAIL ma_sel got %b want 1111", bus_sel); end
        bus_ack = 1'b1; bus_rdata = 32'h11223344;
        tick();
        bus_ack = 1'b0; mem_read = 1'b0;
        nvec++; if (load_data !== 32'h11223344) begin nerr++; $display("FAIL ma_ldata got %08h want 11223344", load_data); end
        tick();
`endif
    endtask

    initial begin
        store_data = 32'h0000ABCD;
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_store();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
